// File: rtl/mips_tlb_mmu.sv
// Joint MIPS32 TLB with registered instruction/data translation, TLBWI/TLBWR/TLBP/TLBR and Random/Wired.
// Optional feature: define TLB_MISS_STATS_EN to add saturating i/d miss counters.
module mips_tlb_mmu #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_va,
    input  logic             d_req,
    input  logic [31:0]      d_va,
    input  logic             d_store,
    input  logic [7:0]       asid,
    input  logic [2:0]       k0_cca,
    output logic [31:0]      i_pa,
    output logic             i_vld,
    output logic             i_uncached,
    output logic             i_miss,
    output logic             i_inv,
    output logic [31:0]      d_pa,
    output logic             d_vld,
    output logic             d_uncached,
    output logic             d_miss,
    output logic             d_inv,
    output logic             d_mod,
    input  logic             tlb_we,
    input  logic             tlb_wr_rand,
    input  logic [IDX_W-1:0] tlb_idx,
    input  logic [31:0]      w_entryhi,
    input  logic [25:0]      w_lo0,
    input  logic [25:0]      w_lo1,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_val,
    input  logic             probe_req,
    output logic             probe_vld,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_idx,
    input  logic             read_req,
    output logic             read_vld,
    output logic [31:0]      r_entryhi,
    output logic [25:0]      r_lo0,
    output logic [25:0]      r_lo1,
    output logic [IDX_W-1:0] random_idx
`ifdef TLB_MISS_STATS_EN
    ,
    output logic [31:0]      i_miss_cnt,
    output logic [31:0]      d_miss_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } match_t;

    typedef struct packed {
        logic [31:0] pa;
        logic        uncached;
        logic        miss;
        logic        inv;
    } xlat_t;

    logic [18:0]            vpn2_q [NUM_ENTRIES];
    logic [7:0]             asid_q [NUM_ENTRIES];
    logic [19:0]            pfn0_q [NUM_ENTRIES];
    logic [19:0]            pfn1_q [NUM_ENTRIES];
    logic [2:0]             c0_q   [NUM_ENTRIES];
    logic [2:0]             c1_q   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] d0_q, d1_q;
    logic [NUM_ENTRIES-1:0] v0_q, v1_q, g_q;

    logic [IDX_W-1:0]       random_q, wired_q, wr_idx;
    logic [NUM_ENTRIES-1:0] i_hv, d_hv, p_hv;
    match_t                 i_m, d_m, p_m;
    xlat_t                  i_x, d_x;
    logic                   i_odd, d_odd, d_dirty, d_valid, d_mod_x;
    logic                   unused_entryhi_bits;

    assign unused_entryhi_bits = ^w_entryhi[12:8];
    assign wr_idx     = tlb_wr_rand ? random_q : tlb_idx;
    assign random_idx = random_q;

    // NOTE: the entry payload is a RAM-like array with no reset; only the V/G bits below are cleared.
    always_ff @(posedge clk) begin
        if (tlb_we) begin
            vpn2_q[wr_idx] <= w_entryhi[31:13];
            asid_q[wr_idx] <= w_entryhi[7:0];
            pfn0_q[wr_idx] <= w_lo0[25:6];
            c0_q[wr_idx]   <= w_lo0[5:3];
            d0_q[wr_idx]   <= w_lo0[2];
            pfn1_q[wr_idx] <= w_lo1[25:6];
            c1_q[wr_idx]   <= w_lo1[5:3];
            d1_q[wr_idx]   <= w_lo1[2];
        end
    end

    // NOTE: non-blocking assignments keep every reader in this cycle on the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= '0;
            v1_q <= '0;
            g_q  <= '0;
        end else if (tlb_we) begin
            v0_q[wr_idx] <= w_lo0[1];
            v1_q[wr_idx] <= w_lo1[1];
            g_q[wr_idx]  <= w_lo0[0] & w_lo1[0];
        end
    end

    // Random counts down through the non-wired entries and reloads at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= LAST_IDX;
            wired_q  <= '0;
        end else begin
            if (wired_we || wired_q >= LAST_IDX || random_q <= wired_q)
                random_q <= LAST_IDX;
            else
                random_q <= random_q - IDX_W'(1);
            if (wired_we)
                wired_q <= wired_val;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        i_hv = '0;
        d_hv = '0;
        p_hv = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            i_hv[e] = (vpn2_q[e] == i_va[31:13]) && (g_q[e] || asid_q[e] == asid);
            d_hv[e] = (vpn2_q[e] == d_va[31:13]) && (g_q[e] || asid_q[e] == asid);
            p_hv[e] = (vpn2_q[e] == w_entryhi[31:13]) && (g_q[e] || asid_q[e] == w_entryhi[7:0]);
        end
    end

    function automatic match_t first_hit(input logic [NUM_ENTRIES-1:0] hv);
        match_t m;
        m = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (hv[e]) begin
                m.hit = 1'b1;
                m.idx = IDX_W'(e);
            end
        end
        return m;
    endfunction

    function automatic xlat_t translate(input logic [31:0] va, input logic [2:0] k0, input logic hit,
                                        input logic [19:0] pfn, input logic [2:0] cca, input logic v);
        xlat_t r;
        r = '0;
        if (va[31:30] == 2'b10) begin
            r.pa       = {3'b000, va[28:0]};
            r.uncached = va[29] || (k0 == 3'b010);
        end else if (!hit) begin
            r.miss = 1'b1;
        end else begin
            r.pa       = {pfn, va[11:0]};
            r.uncached = (cca == 3'b010);
            r.inv      = !v;
        end
        return r;
    endfunction

    assign i_m   = first_hit(i_hv);
    assign d_m   = first_hit(d_hv);
    assign p_m   = first_hit(p_hv);
    assign i_odd = i_va[12];
    assign d_odd = d_va[12];

    assign i_x = translate(i_va, k0_cca, i_m.hit,
                           i_odd ? pfn1_q[i_m.idx] : pfn0_q[i_m.idx],
                           i_odd ? c1_q[i_m.idx]   : c0_q[i_m.idx],
                           i_odd ? v1_q[i_m.idx]   : v0_q[i_m.idx]);
    assign d_x = translate(d_va, k0_cca, d_m.hit,
                           d_odd ? pfn1_q[d_m.idx] : pfn0_q[d_m.idx],
                           d_odd ? c1_q[d_m.idx]   : c0_q[d_m.idx],
                           d_valid);

    assign d_valid = d_odd ? v1_q[d_m.idx] : v0_q[d_m.idx];
    assign d_dirty = d_odd ? d1_q[d_m.idx] : d0_q[d_m.idx];
    assign d_mod_x = d_store && d_m.hit && (d_va[31:30] != 2'b10) && d_valid && !d_dirty;

    // Results are zeroed when no request was made so idle outputs stay quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_vld      <= 1'b0;
            i_pa       <= '0;
            i_uncached <= 1'b0;
            i_miss     <= 1'b0;
            i_inv      <= 1'b0;
            d_vld      <= 1'b0;
            d_pa       <= '0;
            d_uncached <= 1'b0;
            d_miss     <= 1'b0;
            d_inv      <= 1'b0;
            d_mod      <= 1'b0;
            probe_vld  <= 1'b0;
            probe_miss <= 1'b0;
            probe_idx  <= '0;
            read_vld   <= 1'b0;
            r_entryhi  <= '0;
            r_lo0      <= '0;
            r_lo1      <= '0;
        end else begin
            i_vld      <= i_req;
            i_pa       <= i_req ? i_x.pa : '0;
            i_uncached <= i_req && i_x.uncached;
            i_miss     <= i_req && i_x.miss;
            i_inv      <= i_req && i_x.inv;
            d_vld      <= d_req;
            d_pa       <= d_req ? d_x.pa : '0;
            d_uncached <= d_req && d_x.uncached;
            d_miss     <= d_req && d_x.miss;
            d_inv      <= d_req && d_x.inv;
            d_mod      <= d_req && d_mod_x;
            probe_vld  <= probe_req;
            probe_miss <= probe_req && !p_m.hit;
            probe_idx  <= (probe_req && p_m.hit) ? p_m.idx : '0;
            read_vld   <= read_req;
            r_entryhi  <= read_req ? {vpn2_q[tlb_idx], 5'b0, asid_q[tlb_idx]} : '0;
            r_lo0      <= read_req ? {pfn0_q[tlb_idx], c0_q[tlb_idx], d0_q[tlb_idx],
                                      v0_q[tlb_idx], g_q[tlb_idx]} : '0;
            r_lo1      <= read_req ? {pfn1_q[tlb_idx], c1_q[tlb_idx], d1_q[tlb_idx],
                                      v1_q[tlb_idx], g_q[tlb_idx]} : '0;
        end
    end

`ifdef TLB_MISS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_miss_cnt <= '0;
            d_miss_cnt <= '0;
        end else begin
            if (i_req && i_x.miss && i_miss_cnt != 32'hFFFF_FFFF)
                i_miss_cnt <= i_miss_cnt + 32'd1;
            if (d_req && d_x.miss && d_miss_cnt != 32'hFFFF_FFFF)
                d_miss_cnt <= d_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_tlb_mmu.sv
// Scoreboard bench for mips_tlb_mmu: stimulus pushes expected results from a behavioural TLB model,
// a negedge monitor pops and compares whenever the DUT raises a valid.
module tb_mips_tlb_mmu;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req, d_req, d_store, tlb_we, tlb_wr_rand, wired_we, probe_req, read_req;
    logic [31:0]   i_va, d_va, w_entryhi;
    logic [7:0]    asid;
    logic [2:0]    k0_cca;
    logic [25:0]   w_lo0, w_lo1;
    logic [IW-1:0] tlb_idx, wired_val;
    logic [31:0]   i_pa, d_pa, r_entryhi;
    logic          i_vld, i_uncached, i_miss, i_inv;
    logic          d_vld, d_uncached, d_miss, d_inv, d_mod;
    logic          probe_vld, probe_miss, read_vld;
    logic [IW-1:0] probe_idx, random_idx;
    logic [25:0]   r_lo0, r_lo1;

    mips_tlb_mmu #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_va(i_va), .d_req(d_req), .d_va(d_va), .d_store(d_store),
        .asid(asid), .k0_cca(k0_cca),
        .i_pa(i_pa), .i_vld(i_vld), .i_uncached(i_uncached), .i_miss(i_miss), .i_inv(i_inv),
        .d_pa(d_pa), .d_vld(d_vld), .d_uncached(d_uncached), .d_miss(d_miss), .d_inv(d_inv),
        .d_mod(d_mod),
        .tlb_we(tlb_we), .tlb_wr_rand(tlb_wr_rand), .tlb_idx(tlb_idx),
        .w_entryhi(w_entryhi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .wired_we(wired_we), .wired_val(wired_val),
        .probe_req(probe_req), .probe_vld(probe_vld), .probe_miss(probe_miss), .probe_idx(probe_idx),
        .read_req(read_req), .read_vld(read_vld),
        .r_entryhi(r_entryhi), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .random_idx(random_idx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the TLB as plain arrays, indexed [page parity][entry] for the lo halves.
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g    [N];
    logic [19:0] m_pfn  [2][N];
    logic [2:0]  m_c    [2][N];
    logic        m_d    [2][N];
    logic        m_v    [2][N];
    int          m_rand, m_wired;

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        logic        miss;
        logic        inv;
        logic        mod;
    } xexp_t;

    typedef struct packed {
        logic          miss;
        logic [IW-1:0] idx;
    } pexp_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [25:0] lo0;
        logic [25:0] lo1;
    } rexp_t;

    xexp_t iq[$], dq[$];
    pexp_t pq[$];
    rexp_t rq[$];
    xexp_t mon_x;
    pexp_t mon_p;
    rexp_t mon_r;

    function automatic xexp_t mk_x(input logic [31:0] pa, input logic unc, input logic miss,
                                   input logic inv, input logic md);
        xexp_t r;
        r.pa = pa; r.unc = unc; r.miss = miss; r.inv = inv; r.mod = md;
        return r;
    endfunction

    function automatic int find_entry(input logic [18:0] vpn2, input logic [7:0] a);
        for (int e = 0; e < N; e++)
            if (m_vpn2[e] == vpn2 && (m_g[e] || m_asid[e] == a)) return e;
        return -1;
    endfunction

    function automatic xexp_t model_xlat(input logic [31:0] va, input logic st, input logic [7:0] a,
                                         input logic [2:0] k0);
        xexp_t r;
        int    e, s;
        r = '0;
        if (va[31:30] == 2'b10) begin
            r.pa  = va & 32'h1FFF_FFFF;
            r.unc = (va[31:29] == 3'b101) || (k0 == 3'd2);
            return r;
        end
        e = find_entry(va[31:13], a);
        if (e < 0) begin
            r.miss = 1'b1;
            return r;
        end
        s     = va[12] ? 1 : 0;
        r.pa  = {m_pfn[s][e], va[11:0]};
        r.unc = (m_c[s][e] == 3'd2);
        r.inv = !m_v[s][e];
        r.mod = st && m_v[s][e] && !m_d[s][e];
        return r;
    endfunction

    function automatic pexp_t model_probe(input logic [31:0] hi);
        pexp_t r;
        int    e;
        e     = find_entry(hi[31:13], hi[7:0]);
        r.miss = (e < 0);
        r.idx  = (e < 0) ? '0 : IW'(e);
        return r;
    endfunction

    function automatic rexp_t model_read(input int e);
        rexp_t r;
        r.hi  = {m_vpn2[e], 5'b0, m_asid[e]};
        r.lo0 = {m_pfn[0][e], m_c[0][e], m_d[0][e], m_v[0][e], m_g[e]};
        r.lo1 = {m_pfn[1][e], m_c[1][e], m_d[1][e], m_v[1][e], m_g[e]};
        return r;
    endfunction

    task automatic model_write(input int e, input logic [31:0] hi, input logic [25:0] lo0,
                               input logic [25:0] lo1);
        m_vpn2[e]   = hi[31:13];
        m_asid[e]   = hi[7:0];
        m_g[e]      = lo0[0] & lo1[0];
        m_pfn[0][e] = lo0[25:6]; m_c[0][e] = lo0[5:3]; m_d[0][e] = lo0[2]; m_v[0][e] = lo0[1];
        m_pfn[1][e] = lo1[25:6]; m_c[1][e] = lo1[5:3]; m_d[1][e] = lo1[2]; m_v[1][e] = lo1[1];
    endtask

    task automatic model_reset();
        for (int e = 0; e < N; e++) begin
            m_g[e] = 1'b0; m_v[0][e] = 1'b0; m_v[1][e] = 1'b0;
        end
        m_rand  = N - 1;
        m_wired = 0;
    endtask

    // One clock: expectations from the pre-edge model, then the model advances with the edge.
    task automatic step(input bit auto_exp = 1'b1);
        if (auto_exp) begin
            if (i_req)     iq.push_back(model_xlat(i_va, 1'b0, asid, k0_cca));
            if (d_req)     dq.push_back(model_xlat(d_va, d_store, asid, k0_cca));
            if (probe_req) pq.push_back(model_probe(w_entryhi));
            if (read_req)  rq.push_back(model_read(int'(tlb_idx)));
        end
        @(posedge clk);
        if (tlb_we) model_write(tlb_wr_rand ? m_rand : int'(tlb_idx), w_entryhi, w_lo0, w_lo1);
        if (wired_we || m_wired >= N - 1 || m_rand == m_wired) m_rand = N - 1;
        else m_rand = m_rand - 1;
        if (wired_we) m_wired = int'(wired_val);
        #1;
        i_req = 0; d_req = 0; tlb_we = 0; tlb_wr_rand = 0; probe_req = 0; read_req = 0; wired_we = 0;
    endtask

    function automatic logic [18:0] rand_vpn2();
        logic [1:0] top;
        top = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        return {top, 12'h000, 5'($urandom_range(0, 31))};
    endfunction

    function automatic logic [7:0] rand_asid();
        return 8'($urandom_range(5, 7));
    endfunction

    function automatic logic [25:0] rand_lo();
        return {20'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0)};
    endfunction

    function automatic logic [31:0] rand_va();
        case ($urandom_range(0, 4))
            0, 1:    return {rand_vpn2(), 13'($urandom)};
            2:       return {3'b100, 29'($urandom)};
            3:       return {3'b101, 29'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic set_rand_write();
        w_entryhi = {rand_vpn2(), 5'b0, rand_asid()};
        w_lo0     = rand_lo();
        w_lo1     = rand_lo();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (i_vld) begin
                if (iq.size() == 0) check("i_vld_unrequested", i_vld, 1'b0);
                else begin
                    mon_x = iq.pop_front();
                    check("i_xlat", {i_pa, i_uncached, i_miss, i_inv},
                          {mon_x.pa, mon_x.unc, mon_x.miss, mon_x.inv});
                end
            end
            if (d_vld) begin
                if (dq.size() == 0) check("d_vld_unrequested", d_vld, 1'b0);
                else begin
                    mon_x = dq.pop_front();
                    check("d_xlat", {d_pa, d_uncached, d_miss, d_inv, d_mod},
                          {mon_x.pa, mon_x.unc, mon_x.miss, mon_x.inv, mon_x.mod});
                end
            end
            if (probe_vld) begin
                if (pq.size() == 0) check("probe_vld_unrequested", probe_vld, 1'b0);
                else begin
                    mon_p = pq.pop_front();
                    check("probe", {probe_miss, probe_idx}, {mon_p.miss, mon_p.idx});
                end
            end
            if (read_vld) begin
                if (rq.size() == 0) check("read_vld_unrequested", read_vld, 1'b0);
                else begin
                    mon_r = rq.pop_front();
                    check("read_entryhi", r_entryhi, mon_r.hi);
                    check("read_lo", {r_lo0, r_lo1}, {mon_r.lo0, mon_r.lo1});
                end
            end
            check("random_idx", random_idx, m_rand);
        end
    end

    int r_at_wr;

    initial begin
        i_req = 0; d_req = 0; d_store = 0; tlb_we = 0; tlb_wr_rand = 0; wired_we = 0;
        probe_req = 0; read_req = 0; i_va = 0; d_va = 0; w_entryhi = 0; asid = 0; k0_cca = 3'd3;
        w_lo0 = 0; w_lo1 = 0; tlb_idx = 0; wired_val = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", {i_vld, d_vld, probe_vld, read_vld}, 4'b0);
        check("rst_pa", {i_pa, d_pa}, 64'd0);
        check("rst_flags", {i_uncached, i_miss, i_inv, d_uncached, d_miss, d_inv, d_mod,
                            probe_miss, probe_idx, r_lo1}, '0);
        check("rst_read", {r_entryhi, r_lo0}, '0);
        check("rst_random", random_idx, 4'd15);
        model_reset();
        rst = 1'b0;

        for (int e = 0; e < N; e++) begin
            tlb_we = 1; tlb_idx = IW'(e); set_rand_write();
            step();
        end

        // Unmapped segments.
        i_req = 1; i_va = 32'hBFC0_0000; k0_cca = 3'd3;
        iq.push_back(mk_x(32'h1FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0);
        d_req = 1; d_va = 32'h8000_1234; d_store = 0;
        dq.push_back(mk_x(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0);
        d_req = 1; k0_cca = 3'd2;
        dq.push_back(mk_x(32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0);
        k0_cca = 3'd3;

        // TLBWI entry 3, then store hit on the odd page with D=0, then ASID mismatch.
        tlb_we = 1; tlb_idx = 4'd3; w_entryhi = 32'h0040_0005;
        w_lo0 = {20'h00000, 3'd3, 1'b0, 1'b0, 1'b0};
        w_lo1 = {20'h12345, 3'd3, 1'b0, 1'b1, 1'b0};
        step();
        d_req = 1; d_va = 32'h0040_1ABC; asid = 8'd5; d_store = 1;
        dq.push_back(mk_x(32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b1));
        step(1'b0);
        d_req = 1; asid = 8'd6;
        dq.push_back(mk_x(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0));
        step(1'b0);

        probe_req = 1; w_entryhi = 32'h0040_0005;
        pq.push_back(pexp_t'{1'b0, 4'd3});
        step(1'b0);
        probe_req = 1; w_entryhi = {19'h12345, 5'b0, 8'd5};
        pq.push_back(pexp_t'{1'b1, 4'd0});
        step(1'b0);

        // Write and lookup in one cycle: old mapping, then the new one.
        tlb_we = 1; tlb_idx = 4'd3; w_entryhi = 32'h0040_0005;
        w_lo0 = {20'h00000, 3'd3, 1'b0, 1'b0, 1'b0};
        w_lo1 = {20'h54321, 3'd3, 1'b1, 1'b1, 1'b0};
        d_req = 1; d_va = 32'h0040_1ABC; asid = 8'd5; d_store = 1;
        dq.push_back(mk_x(32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b1));
        step(1'b0);
        d_req = 1;
        dq.push_back(mk_x(32'h5432_1ABC, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0);

        // Wired = 4: Random walks 15..4 and wraps; TLBWR lands on the current Random.
        wired_we = 1; wired_val = 4'd4;
        step();
        repeat (30) step();
        r_at_wr = m_rand;
        tlb_we = 1; tlb_wr_rand = 1; tlb_idx = 4'd0; set_rand_write();
        step();
        read_req = 1; tlb_idx = IW'(r_at_wr);
        step();
        repeat (5) step();
        wired_we = 1; wired_val = 4'd4;
        step();

        for (int c = 0; c < 600; c++) begin
            i_req = ($urandom_range(0, 3) != 0); i_va = rand_va();
            d_req = ($urandom_range(0, 3) != 0); d_va = rand_va(); d_store = 1'($urandom_range(0, 1));
            asid = rand_asid(); k0_cca = 3'($urandom_range(0, 7));
            set_rand_write();
            probe_req = ($urandom_range(0, 3) == 0);
            read_req = ($urandom_range(0, 3) == 0); tlb_idx = IW'($urandom_range(0, N - 1));
            tlb_we = ($urandom_range(0, 5) == 0); tlb_wr_rand = 1'($urandom_range(0, 1));
            wired_we = ($urandom_range(0, 39) == 0); wired_val = IW'($urandom_range(0, N - 1));
            step();

            if (c == 300) begin
                i_req = 1; d_req = 1; probe_req = 1; read_req = 1;
                step();
                rst = 1'b1;
                #1;
                check("async_rst_vld", {i_vld, d_vld, probe_vld, read_vld}, 4'b0);
                check("async_rst_random", random_idx, 4'd15);
                iq.delete(); dq.delete(); pq.delete(); rq.delete();
                model_reset();
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        repeat (3) step();
        check("i_pending", iq.size(), 0);
        check("d_pending", dq.size(), 0);
        check("probe_pending", pq.size(), 0);
        check("read_pending", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
